psr_window_unit: RTL

- Processor state register stage directly downstream of the 32-bit ALU.
- Latches the ALU's N/Z/V/C flags into the integer condition codes (icc) on S-bit operations.
- Returns the registered carry to the ALU `carry` input for ADDX/SUBX, and evaluates Bicc branch conditions.
- Owns the current window pointer (CWP), window invalid mask (WIM), and S/PS/ET trap state, with SAVE/RESTORE/RETT/trap-entry sequencing.

---
 rtl/psr_window_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/psr_window_unit.sv
// psr_window_unit: processor state register stage behind the ALU.
// Holds icc (N/Z/V/C), S/PS/ET trap state, CWP and WIM, and sequences
// SAVE/RESTORE/RETT/trap entry with window overflow/underflow detection.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   alu_n/z/v/c, alu_opcode    ALU flags and opcode; icc_we commits a flag load
//   carry_out                  registered icc.C back to the ALU carry input
//   cond, cond_true            Bicc condition field and its evaluation on icc
//   save, restore, rett        window requests (single-cycle strobes)
//   trap_req                   trap entry request
//   wr_psr, wr_wim, wr_data    PSR / WIM writes
//   psr, wim, cwp              architectural state views
//   win_ovf, win_unf, illegal  one-cycle registered event pulses
//   error_mode                 sticky; trap taken while traps disabled
module psr_window_unit #(
  parameter int NWIN = 8,
  parameter int CWPW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_n,
  input  logic            alu_z,
  input  logic            alu_v,
  input  logic            alu_c,
  input  logic [5:0]      alu_opcode,
  input  logic            icc_we,
  output logic            carry_out,
  input  logic [3:0]      cond,
  output logic            cond_true,
  input  logic            save,
  input  logic            restore,
  input  logic            rett,
  input  logic            trap_req,
  input  logic            wr_psr,
  input  logic            wr_wim,
  input  logic [31:0]     wr_data,
  output logic [31:0]     psr,
  output logic [NWIN-1:0] wim,
  output logic [CWPW-1:0] cwp,
  output logic            win_ovf,
  output logic            win_unf,
  output logic            illegal,
  output logic            error_mode
);
  localparam logic [CWPW-1:0] CWP_MAX = CWPW'(NWIN - 1);
  localparam logic [5:0] NWIN6 = 6'(NWIN);
  logic [3:0] icc;
  logic s, ps, et;
  logic [CWPW-1:0] cwp_dn, cwp_up;
  logic blk_dn, blk_up, psr_ok, cc_load, base;
  logic unused_bits;
  always_comb begin
    cwp_dn = (cwp == '0) ? CWP_MAX : cwp - 1'b1;
    cwp_up = (cwp == CWP_MAX) ? '0 : cwp + 1'b1;
    blk_dn = |(wim & (NWIN'(1) << cwp_dn));
    blk_up = |(wim & (NWIN'(1) << cwp_up));
    psr_ok = {1'b0, wr_data[4:0]} < NWIN6;
    // Flag loads yield to any request that rewrites icc or changes trap state.
    cc_load = icc_we && !trap_req && !wr_psr && !rett && alu_opcode[5:4] == 2'b01;
    // icc = {N, Z, V, C}; cond[3] inverts the sense of cond[2:0].
    base = cond[2] ? (cond[1] ? (cond[0] ? icc[1] : icc[3])
                              : (cond[0] ? icc[0] : icc[0] | icc[2]))
                   : (cond[1] ? (cond[0] ? icc[3] ^ icc[1] : icc[2] | (icc[3] ^ icc[1]))
                              : (cond[0] & icc[2]));
    cond_true = cond[3] ^ base;
  end
  assign carry_out = icc[0];
  assign psr = {8'h00, icc, 12'h000, s, ps, et, 5'(cwp)};
  assign unused_bits = ^{wr_data, alu_opcode[3:2]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icc <= 4'h0;
      s <= 1'b1;
      ps <= 1'b0;
      et <= 1'b0;
      cwp <= '0;
      wim <= '0;
      error_mode <= 1'b0;
      win_ovf <= 1'b0;
      win_unf <= 1'b0;
      illegal <= 1'b0;
    end else begin
      win_ovf <= 1'b0;
      win_unf <= 1'b0;
      illegal <= 1'b0;
      if (!error_mode) begin
        if (trap_req) begin
          if (et) begin
            et <= 1'b0;
            ps <= s;
            s <= 1'b1;
            cwp <= cwp_dn;
          end else error_mode <= 1'b1;
        end else if (wr_psr) begin
          if (psr_ok) begin
            icc <= wr_data[23:20];
            s <= wr_data[7];
            ps <= wr_data[6];
            et <= wr_data[5];
            cwp <= CWPW'(wr_data[4:0]);
          end else illegal <= 1'b1;
        end else if (rett) begin
          if (et) illegal <= 1'b1;
          else if (blk_up) win_unf <= 1'b1;
          else begin
            cwp <= cwp_up;
            s <= ps;
            et <= 1'b1;
          end
        end else if (save) begin
          if (blk_dn) win_ovf <= 1'b1;
          else cwp <= cwp_dn;
        end else if (restore) begin
          if (blk_up) win_unf <= 1'b1;
          else cwp <= cwp_up;
        end
        if (cc_load) icc <= (alu_opcode[1:0] == 2'b00) ? {alu_n, alu_z, alu_v, alu_c} : {alu_n, alu_z, 2'b00};
        // WIM write lands on the same edge, so same-cycle window checks use the old mask.
        if (wr_wim) wim <= wr_data[NWIN-1:0];
      end
    end
  end
endmodule
